carry_save_adder: RTL and testbench

Registered WIDTH-bit carry-save adder (3:2 compressor) reducing three operands A, B, Cin to a bitwise sum vector and a bitwise carry vector without carry propagation. It is the reduction stage of multi-operand adders and multiplier partial-product trees, feeding a downstream carry-propagate adder or a further CSA level. An optional built-in final adder produces the fully resolved total.

---
 rtl/carry_save_adder_if.sv | 31 +++
 rtl/carry_save_adder.sv | 59 +++++
 tb/tb_carry_save_adder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/carry_save_adder_if.sv
// rtl/carry_save_adder_if.sv - operand/result bundle for carry_save_adder (Total present with CSA_FINAL_ADD_EN)
interface carry_save_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Cin;
    logic [WIDTH-1:0] Sum;
    logic [WIDTH-1:0] Cout;
    logic             out_valid;
`ifdef CSA_FINAL_ADD_EN
    logic [WIDTH+1:0] Total;
`endif

    modport master (
        output in_valid, A, B, Cin,
        input  Sum, Cout, out_valid
`ifdef CSA_FINAL_ADD_EN
        , input Total
`endif
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output Sum, Cout, out_valid
`ifdef CSA_FINAL_ADD_EN
        , output Total
`endif
    );
endinterface

// File: rtl/carry_save_adder.sv
// rtl/carry_save_adder.sv - registered WIDTH-bit 3:2 compressor; CSA_FINAL_ADD_EN adds a registered resolved Total
module carry_save_adder #(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    carry_save_adder_if.slave bus
);
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] cout_next;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] cout_q;
    logic             valid_q;

    // Each bit is an independent full adder; Cout keeps its own bit index (weight 2^(i+1)).
    always_comb begin
        sum_next  = bus.A ^ bus.B ^ bus.Cin;
        cout_next = (bus.A & bus.B) | (bus.B & bus.Cin) | (bus.Cin & bus.A);
    end

    // Data registers only load on a qualified input, so unknown operands never reach them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_next;
                cout_q <= cout_next;
            end
        end
    end

    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = valid_q;

`ifdef CSA_FINAL_ADD_EN
    logic [WIDTH+1:0] total_next;
    logic [WIDTH+1:0] total_q;

    // Two guard bits cover the worst case 3*(2^WIDTH-1).
    always_comb begin
        total_next = {2'b00, sum_next} + {1'b0, cout_next, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
        end else if (bus.in_valid) begin
            total_q <= total_next;
        end
    end

    assign bus.Total = total_q;
`endif
endmodule

// File: tb/tb_carry_save_adder.sv
// tb/tb_carry_save_adder.sv - scoreboard bench for carry_save_adder (Total checks under CSA_FINAL_ADD_EN)
module tb_carry_save_adder;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    carry_save_adder_if #(.WIDTH(W)) bus ();
    carry_save_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W+1:0] t;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t held;
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        exp_t r;
        for (int i = 0; i < W; i++) begin
            r.s[i] = (a[i] + b[i] + c[i]) % 2;
            r.c[i] = (a[i] + b[i] + c[i]) >= 2;
        end
        r.t = (W+2)'(a) + (W+2)'(b) + (W+2)'(c);
        return r;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input logic v);
        bus.A = a; bus.B = b; bus.Cin = c; bus.in_valid = v;
        if (v === 1'b1) sb.push_back(model(a, b, c));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            e = '0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(4'hF, 4'hF, 4'hF, 1'b1);
        sb.delete();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_async_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.Sum !== '0) begin failures++; $display("FAIL reset_async_sum: got %h want 0", bus.Sum); end
        tick; tick;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_wins_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.Sum !== '0 || bus.Cout !== '0) begin failures++; $display("FAIL reset_wins_data: sum %h cout %h want 0 0", bus.Sum, bus.Cout); end
`ifdef CSA_FINAL_ADD_EN
        checks++; if (bus.Total !== '0) begin failures++; $display("FAIL reset_total: got %0d want 0", bus.Total); end
`endif
        rst = 1'b0;
        drive('0, '0, '0, 1'b0);
    endtask

    task automatic test_basic;
        logic [W-1:0] ta [2] = '{4'b1011, 4'b1111};
        logic [W-1:0] tb [2] = '{4'b0010, 4'b1111};
        logic [W-1:0] tc [2] = '{4'b0010, 4'b0011};
        logic [W-1:0] ws [2] = '{4'b1011, 4'b0011};
        logic [W-1:0] wc [2] = '{4'b0010, 4'b1111};
        int           wt [2] = '{15, 33};
        for (int i = 0; i < 2; i++) begin
            drive(ta[i], tb[i], tc[i], 1'b1);
            tick;
            drive('0, '0, '0, 1'b0);
            pop_exp;
            checks++; if (bus.Sum !== ws[i] || bus.Sum !== e.s) begin failures++; $display("FAIL basic_sum[%0d]: got %b want %b", i, bus.Sum, ws[i]); end
            checks++; if (bus.Cout !== wc[i] || bus.Cout !== e.c) begin failures++; $display("FAIL basic_cout[%0d]: got %b want %b", i, bus.Cout, wc[i]); end
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d]: got %b want 1", i, bus.out_valid); end
`ifdef CSA_FINAL_ADD_EN
            checks++; if (int'(bus.Total) != wt[i] || bus.Total !== e.t) begin failures++; $display("FAIL basic_total[%0d]: got %0d want %0d", i, bus.Total, wt[i]); end
`endif
            tick;
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop[%0d]: got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back;
        drive(4'hF, 4'hF, 4'hF, 1'b1);
        tick;
        drive(4'b0001, 4'b0010, 4'b0001, 1'b1);
        pop_exp;
        checks++; if (bus.Sum !== 4'b1111 || bus.Cout !== 4'b1111 || bus.Sum !== e.s) begin failures++; $display("FAIL b2b_first: sum %b cout %b want 1111 1111", bus.Sum, bus.Cout); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid: got %b want 1", bus.out_valid); end
`ifdef CSA_FINAL_ADD_EN
        checks++; if (int'(bus.Total) != 45) begin failures++; $display("FAIL b2b_first_total: got %0d want 45", bus.Total); end
`endif
        tick;
        drive('0, '0, '0, 1'b0);
        pop_exp;
        checks++; if (bus.Sum !== 4'b0010 || bus.Cout !== 4'b0001 || bus.Cout !== e.c) begin failures++; $display("FAIL b2b_second: sum %b cout %b want 0010 0001", bus.Sum, bus.Cout); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid: got %b want 1", bus.out_valid); end
`ifdef CSA_FINAL_ADD_EN
        checks++; if (int'(bus.Total) != 4) begin failures++; $display("FAIL b2b_second_total: got %0d want 4", bus.Total); end
`endif
        tick;
    endtask

    task automatic test_hold;
        drive(4'b0101, 4'b1010, 4'b0010, 1'b1);
        tick;
        drive(4'hF, 4'hF, 4'hF, 1'b0);
        pop_exp;
        held = e;
        checks++; if (bus.Sum !== 4'b1101 || bus.Cout !== 4'b0010) begin failures++; $display("FAIL hold_load: sum %b cout %b want 1101 0010", bus.Sum, bus.Cout); end
        for (int i = 0; i < 2; i++) begin
            tick;
            drive('x, 'x, 'x, 1'b0);
            checks++; if (bus.Sum !== held.s || bus.Cout !== held.c) begin failures++; $display("FAIL hold_data[%0d]: sum %b cout %b want %b %b", i, bus.Sum, bus.Cout, held.s, held.c); end
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_valid[%0d]: got %b want 0", i, bus.out_valid); end
`ifdef CSA_FINAL_ADD_EN
            checks++; if (int'(bus.Total) != 17) begin failures++; $display("FAIL hold_total[%0d]: got %0d want 17", i, bus.Total); end
`endif
        end
        drive('0, '0, '0, 1'b0);
    endtask

    task automatic test_async_reset;
        drive(4'b0011, 4'b0101, 4'b0110, 1'b1);
        tick;
        pop_exp;
        checks++; if (bus.out_valid !== 1'b1 || bus.Sum !== e.s) begin failures++; $display("FAIL arst_pre: valid %b sum %b want 1 %b", bus.out_valid, bus.Sum, e.s); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.Sum !== '0 || bus.Cout !== '0) begin failures++; $display("FAIL arst_data: sum %b cout %b want 0 0", bus.Sum, bus.Cout); end
`ifdef CSA_FINAL_ADD_EN
        checks++; if (bus.Total !== '0) begin failures++; $display("FAIL arst_total: got %0d want 0", bus.Total); end
`endif
        #1 rst = 1'b0;
        sb.delete();
        drive(4'b0001, 4'b0010, 4'b0001, 1'b1);
        tick;
        drive('0, '0, '0, 1'b0);
        pop_exp;
        checks++; if (bus.Sum !== 4'b0010 || bus.Cout !== 4'b0001 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_after: sum %b cout %b valid %b want 0010 0001 1", bus.Sum, bus.Cout, bus.out_valid); end
        tick;
    endtask

    task automatic test_sweep;
        logic [W-1:0] av [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        logic [W-1:0] bv [3] = '{4'd0, 4'd7, 4'd14};
        logic [W-1:0] cv [2] = '{4'd0, 4'd9};
        logic [W+1:0] want;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 2; k++) begin
                    drive(av[i], bv[j], cv[k], 1'b1);
                    want = (W+2)'(av[i]) + (W+2)'(bv[j]) + (W+2)'(cv[k]);
                    tick;
                    pop_exp;
                    checks++; if (bus.Sum !== e.s || bus.Cout !== e.c) begin failures++; $display("FAIL sweep_bits a=%0d b=%0d c=%0d: sum %b cout %b want %b %b", av[i], bv[j], cv[k], bus.Sum, bus.Cout, e.s, e.c); end
                    checks++; if (({2'b00, bus.Sum} + {1'b0, bus.Cout, 1'b0}) !== want) begin failures++; $display("FAIL sweep_invariant a=%0d b=%0d c=%0d: got %0d want %0d", av[i], bv[j], cv[k], {2'b00, bus.Sum} + {1'b0, bus.Cout, 1'b0}, want); end
                    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL sweep_valid: got %b want 1", bus.out_valid); end
`ifdef CSA_FINAL_ADD_EN
                    checks++; if (bus.Total !== want) begin failures++; $display("FAIL sweep_total: got %0d want %0d", bus.Total, want); end
`endif
                end
        drive('0, '0, '0, 1'b0);
        tick;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_hold;
        test_async_reset;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
